// File: rtl/openadc_cmd_master.sv
// Host-side initiator for the OpenADC serial register protocol: requests -> header/data bytes, rx bytes -> responses.
// Latency: first tx_start 1 cycle after acceptance; rsp_valid 1 cycle after rx_ready; done 1 cycle after last byte.
// Backpressure: req_ready only in IDLE; tx waits on tx_busy. Optional read timeout via `define CMD_TIMEOUT_EN.
module openadc_cmd_master #(
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic        ftdi_clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [5:0]  req_addr,
   input  logic [7:0]  req_wdata,
   input  logic [15:0] req_rdlen,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   input  logic        tx_busy,
   input  logic        rx_ready,
   input  logic [7:0]  rx_data,
   output logic        rsp_valid,
   output logic [7:0]  rsp_data,
   output logic        rsp_last,
   output logic        done,
   output logic        timeout_err,
   output logic [7:0]  rx_stray_cnt
);

   typedef enum logic [2:0] {
      IDLE, SEND_HDR, WAIT_HDR, SEND_DATA, WAIT_DATA, RECV, DONE
   } state_t;

   state_t      state, state_nxt;
   logic        lat_write;
   logic [5:0]  lat_addr;
   logic [7:0]  lat_wdata;
   logic [15:0] lat_rdlen;
   logic [15:0] remain;
   logic        accept, fire_hdr, fire_data, rx_take, rx_end, tout_hit;

   assign req_ready = (state == IDLE);

`ifdef CMD_TIMEOUT_EN
   logic [31:0] tout_cnt;

   assign tout_hit = (state == RECV) && !rx_ready && (tout_cnt == 32'(TIMEOUT_CYCLES - 1));

   // Idle-gap counter: held at zero outside RECV so it starts clean on entry; any rx byte restarts it.
   always_ff @(posedge ftdi_clk or posedge reset) begin
      if (reset)                          tout_cnt <= '0;
      else if (state != RECV || rx_ready) tout_cnt <= '0;
      else                                tout_cnt <= tout_cnt + 32'd1;
   end

   // Sticky abort flag, cleared only when a new request is taken.
   always_ff @(posedge ftdi_clk or posedge reset) begin
      if (reset)         timeout_err <= 1'b0;
      else if (accept)   timeout_err <= 1'b0;
      else if (tout_hit) timeout_err <= 1'b1;
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
   assign tout_hit    = 1'b0;
   assign timeout_err = 1'b0;
`endif

   // Next-state and per-cycle strobes. A registered tx_start still high means the
   // previous pulse was last cycle: this both blocks back-to-back pulses and gives
   // the wait states their one-cycle minimum before trusting tx_busy.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      fire_hdr  = 1'b0;
      fire_data = 1'b0;
      rx_take   = 1'b0;
      rx_end    = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               accept    = 1'b1;
               state_nxt = SEND_HDR;
            end
         end
         SEND_HDR: begin
            if (!tx_busy && !tx_start) begin
               fire_hdr  = 1'b1;
               state_nxt = lat_write ? WAIT_HDR : RECV;
            end
         end
         WAIT_HDR: begin
            if (!tx_start && !tx_busy) state_nxt = SEND_DATA;
         end
         SEND_DATA: begin
            if (!tx_start) begin
               fire_data = 1'b1;
               state_nxt = WAIT_DATA;
            end
         end
         WAIT_DATA: begin
            if (!tx_start && !tx_busy) state_nxt = DONE;
         end
         RECV: begin
            if (rx_ready) begin
               rx_take = 1'b1;
               if (remain == 16'd1) begin
                  rx_end    = 1'b1;
                  state_nxt = DONE;
               end
            end else if (tout_hit) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge ftdi_clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Capture the request so the inputs may change once it is accepted.
   always_ff @(posedge ftdi_clk or posedge reset) begin
      if (reset) begin
         lat_write <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_rdlen <= '0;
      end else if (accept) begin
         lat_write <= req_write;
         lat_addr  <= req_addr;
         lat_wdata <= req_wdata;
         lat_rdlen <= req_rdlen;
      end
   end

   // Remaining response bytes; a zero length still asks for one byte.
   always_ff @(posedge ftdi_clk or posedge reset) begin
      if (reset)                        remain <= '0;
      else if (fire_hdr && !lat_write)  remain <= (lat_rdlen == 16'd0) ? 16'd1 : lat_rdlen;
      else if (rx_take)                 remain <= remain - 16'd1;
   end

   // Transmit strobe and byte: header is {1, write, addr}, then write data.
   always_ff @(posedge ftdi_clk or posedge reset) begin
      if (reset) begin
         tx_start <= 1'b0;
         tx_data  <= '0;
      end else begin
         tx_start <= fire_hdr | fire_data;
         if (fire_hdr)       tx_data <= {1'b1, lat_write, lat_addr};
         else if (fire_data) tx_data <= lat_wdata;
      end
   end

   // Forward response bytes and the completion pulse.
   always_ff @(posedge ftdi_clk or posedge reset) begin
      if (reset) begin
         rsp_valid <= 1'b0;
         rsp_last  <= 1'b0;
         rsp_data  <= '0;
         done      <= 1'b0;
      end else begin
         rsp_valid <= rx_take;
         rsp_last  <= rx_end;
         done      <= (state == DONE);
         if (rx_take) rsp_data <= rx_data;
      end
   end

   // Count bytes arriving when no read is collecting them; saturates.
   always_ff @(posedge ftdi_clk or posedge reset) begin
      if (reset)                                               rx_stray_cnt <= '0;
      else if (rx_ready && state != RECV && rx_stray_cnt != 8'hFF) rx_stray_cnt <= rx_stray_cnt + 8'd1;
   end

endmodule

// File: tb/tb_openadc_cmd_master.sv
// Randomized bench for openadc_cmd_master with a transaction-level reference model.
// Expected tx bytes, responses and counters come from the protocol rules, not the RTL.
// A simple transmitter model raises tx_busy one cycle after each tx_start.
module tb_openadc_cmd_master;

   logic        ftdi_clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid, req_ready, req_write;
   logic [5:0]  req_addr;
   logic [7:0]  req_wdata;
   logic [15:0] req_rdlen;
   logic        tx_start, tx_busy;
   logic [7:0]  tx_data;
   logic        rx_ready;
   logic [7:0]  rx_data;
   logic        rsp_valid, rsp_last, done, timeout_err;
   logic [7:0]  rsp_data, rx_stray_cnt;

   int checks = 0, failures = 0;
   int cyc = 0, rsp_cnt = 0, done_cnt = 0, viol = 0, done_cyc = 0;
   int busy_left = 0, stray_exp = 0;
   bit prev_tx = 1'b0, pend = 1'b0;
   logic [7:0] tx_q[$];

   openadc_cmd_master #(.TIMEOUT_CYCLES(64)) dut (
      .ftdi_clk(ftdi_clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_rdlen(req_rdlen),
      .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
      .rx_ready(rx_ready), .rx_data(rx_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
      .done(done), .timeout_err(timeout_err), .rx_stray_cnt(rx_stray_cnt)
   );

   always #5 ftdi_clk = ~ftdi_clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge ftdi_clk);
      #1;
   endtask

   // Monitor plus transmitter model, both at the falling edge.
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(negedge ftdi_clk);
         cyc++;
         if (tx_start) begin
            tx_q.push_back(tx_data);
            if (prev_tx || tx_busy) viol++;
         end
         prev_tx = tx_start;
         if (rsp_valid) rsp_cnt++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (tx_start) pend = 1'b1;
         else if (pend) begin
            pend = 1'b0;
            busy_left = $urandom_range(1, 5);
         end
         tx_busy = (busy_left > 0);
         if (busy_left > 0) busy_left--;
      end
   end

   task automatic check_reset_vals(input string p);
      chk({p, "_req_ready"}, req_ready, 1);
      chk({p, "_tx_start"}, tx_start, 0);
      chk({p, "_tx_data"}, tx_data, 0);
      chk({p, "_rsp_valid"}, rsp_valid, 0);
      chk({p, "_rsp_data"}, rsp_data, 0);
      chk({p, "_rsp_last"}, rsp_last, 0);
      chk({p, "_done"}, done, 0);
      chk({p, "_timeout_err"}, timeout_err, 0);
      chk({p, "_stray"}, rx_stray_cnt, 0);
   endtask

   task automatic issue(input logic wr, input logic [5:0] a, input logic [7:0] d, input logic [15:0] len);
      int t = 0;
      while (!req_ready && t < 100) begin
         tick();
         t++;
      end
      chk("req_ready_idle", req_ready, 1);
      req_write = wr;
      req_addr  = a;
      req_wdata = d;
      req_rdlen = len;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      chk("req_ready_drop", req_ready, 0);
   endtask

   task automatic wr(input logic [5:0] a, input logic [7:0] d);
      int t0 = tx_q.size();
      int d0 = done_cnt;
      int r0 = rsp_cnt;
      int t = 0;
      issue(1'b1, a, d, 16'd0);
      while (done_cnt == d0 && t < 100) begin
         tick();
         t++;
      end
      chk("wr_done", done_cnt - d0, 1);
      chk("wr_ntx", tx_q.size() - t0, 2);
      if (tx_q.size() - t0 == 2) begin
         chk("wr_hdr", tx_q[t0], {2'b11, a});
         chk("wr_dat", tx_q[t0 + 1], d);
      end
      chk("wr_norsp", rsp_cnt - r0, 0);
      chk("guard", viol, 0);
      tick();
      chk("wr_done_pulse", done, 0);
   endtask

   // Read of len bytes; fixed supplies leading bytes, the rest are random.
   // stop_after >= 0 returns after that many bytes, leaving the read open.
   task automatic rd(input logic [5:0] a, input logic [15:0] len, input logic [7:0] fixed[$], input int stop_after);
      int n = (len == 16'd0) ? 1 : int'(len);
      int t0 = tx_q.size();
      int r0 = rsp_cnt;
      int t = 0;
      logic seen;
      logic [7:0] b;
      issue(1'b0, a, 8'h00, len);
      chk("tout_clr", timeout_err, 0);
      while (!tx_start && t < 100) begin
         tick();
         t++;
      end
      seen = tx_start;
      chk("rd_hdr_seen", seen, 1);
      if (!seen) return;
      chk("rd_hdr", tx_q[tx_q.size() - 1], {2'b10, a});
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) tick();
      for (int i = 0; i < n; i++) begin
         if (i == stop_after) return;
         b = (i < fixed.size()) ? fixed[i] : 8'($urandom);
         rx_data  = b;
         rx_ready = 1'b1;
         tick();
         rx_ready = 1'b0;
         chk("rsp_valid", rsp_valid, 1);
         chk("rsp_data", rsp_data, b);
         chk("rsp_last", rsp_last, (i == n - 1));
         if (i < n - 1) begin
            chk("early_done", done, 0);
            repeat ($urandom_range(0, 2)) tick();
         end
      end
      tick();
      chk("rd_done", done, 1);
      chk("rsp_pulse", rsp_valid, 0);
      chk("rd_nrsp", rsp_cnt - r0, n);
      chk("rd_ntx", tx_q.size() - t0, 1);
      chk("guard", viol, 0);
   endtask

   task automatic stray(input int k);
      int r0 = rsp_cnt;
      repeat (k) begin
         rx_data  = 8'($urandom);
         rx_ready = 1'b1;
         tick();
         rx_ready = 1'b0;
         tick();
      end
      stray_exp = (stray_exp + k > 255) ? 255 : stray_exp + k;
      chk("stray_cnt", rx_stray_cnt, stray_exp);
      chk("stray_norsp", rsp_cnt - r0, 0);
   endtask

   initial begin
      logic [7:0] none[$];
      logic [7:0] q1[$];
      logic [7:0] q4[$];
      int d0, r0, c0, t;
      q1 = '{8'h33};
      q4 = '{8'h81, 8'h22, 8'h80, 8'h7F};
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_rdlen = '0;
      rx_ready = 1'b0; rx_data = '0;

      #2 reset = 1'b1;
      tick(); tick();
      check_reset_vals("rst");
      reset = 1'b0;
      tick();
      check_reset_vals("post_rst");

      wr(6'd0, 8'h5A);
      rd(6'd4, 16'd1, q1, -1);
      rd(6'd3, 16'd4, q4, -1);
      rd(6'd3, 16'd0, none, -1);
      stray(3);

      for (int i = 0; i < 20; i++) begin
         if ($urandom_range(0, 1) == 1) wr(6'($urandom), 8'($urandom));
         else rd(6'($urandom), 16'($urandom_range(0, 6)), none, -1);
         stray($urandom_range(0, 2));
      end
      rd(6'd17, 16'd300, none, -1);

      d0 = done_cnt;
      r0 = rsp_cnt;
      issue(1'b0, 6'd2, 8'h00, 16'd1);
      t = 0;
      while (!tx_start && t < 100) begin
         tick();
         t++;
      end
      c0 = cyc;
`ifdef CMD_TIMEOUT_EN
      t = 0;
      while (done_cnt == d0 && t < 200) begin
         tick();
         t++;
      end
      chk("tout_done", done_cnt - d0, 1);
      chk("tout_cycles", done_cyc - c0, 65);
      chk("tout_err", timeout_err, 1);
      chk("tout_norsp", rsp_cnt - r0, 0);
      tick(); tick();
      chk("tout_hold", timeout_err, 1);
      rd(6'd5, 16'd2, none, -1);
`else
      repeat (200) tick();
      chk("recv_wait", done_cnt - d0, 0);
      chk("recv_norsp", rsp_cnt - r0, 0);
      chk("tout_tied", timeout_err, 0);
      chk("recv_busy", req_ready, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      stray_exp = 0;
      tick();
`endif

      stray(2);
      rd(6'd3, 16'd4, none, 2);
      reset = 1'b1;
      #1;
      check_reset_vals("midrst");
      tick();
      reset = 1'b0;
      stray_exp = 0;
      tick();
      check_reset_vals("midrst_post");
      rd(6'd3, 16'd4, q4, -1);

      stray(300);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/openadc_cmd_master.md
# openadc_cmd_master

Host-side initiator for the OpenADC serial register protocol. It turns parallel register read/write requests into the byte stream the capture board's register interface expects, and collects the response bytes from the UART receiver. It sits between a byte-level async_transmitter/async_receiver pair and an on-chip sequencer or loopback test harness. It drives a board-side register interface across a serial link.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1000000: idle ftdi_clk cycles allowed between response bytes before a read aborts. Used only with CMD_TIMEOUT_EN.

Ports:
- ftdi_clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  6  register address.
- req_wdata  in  8  write data.
- req_rdlen  in  16  number of response bytes expected on a read; 0 is treated as 1.
- tx_start  out  1  one-cycle pulse to the transmitter.
- tx_data  out  8  byte to transmit; valid while tx_start is high.
- tx_busy  in  1  transmitter busy.
- rx_ready  in  1  one-cycle pulse from the receiver; a byte is available.
- rx_data  in  8  received byte.
- rsp_valid  out  1  one-cycle pulse; rsp_data is valid.
- rsp_data  out  8  response byte.
- rsp_last  out  1  high with the final rsp_valid of a read.
- done  out  1  one-cycle pulse when a transaction completes or aborts.
- timeout_err  out  1  the last read aborted on timeout.
- rx_stray_cnt  out  8  saturating count of bytes received outside RECV.

## Operation
- Header byte is {1'b1, req_write, req_addr}. Write: header followed by req_wdata. Read: header, then req_rdlen bytes are received.
- States:
  - IDLE: req_ready=1. On req_valid, latch the request, clear timeout_err, go to SEND_HDR.
  - SEND_HDR: when tx_busy=0 and the guard is clear, pulse tx_start with the header. Write goes to WAIT_HDR. Read loads the remaining-byte counter with max(req_rdlen,1), clears the timeout counter, and goes to RECV.
  - WAIT_HDR: wait at least one cycle, then until tx_busy=0, then go to SEND_DATA.
  - SEND_DATA: pulse tx_start with the write data, go to WAIT_DATA.
  - WAIT_DATA: wait at least one cycle, then until tx_busy=0, then go to DONE.
  - RECV: each rx_ready registers rx_data into rsp_data, pulses rsp_valid, and decrements the counter. When the counter reaches 1 on a received byte, also assert rsp_last and go to DONE.
  - DONE: pulse done for one cycle, then go to IDLE.
- Guard: tx_start never fires in two consecutive cycles. The one-cycle minimum wait covers tx_busy rising one cycle late.
- rx_ready in any state other than RECV increments rx_stray_cnt, saturating at 255. That byte is not forwarded.
- The remaining-byte counter is 16 bits. A len of 65535 runs to completion without wrapping.

## Timing
- Reset values: state IDLE, req_ready=1, tx_start=0, tx_data=0, rsp_valid=0, rsp_data=0, rsp_last=0, done=0, timeout_err=0, rx_stray_cnt=0.
- Request acceptance: 1 cycle after req_valid is sampled in IDLE, req_ready drops.
- First tx_start: earliest 1 cycle after acceptance.
- rsp_valid: 1 cycle after rx_ready.
- done (read): 1 cycle after the last rsp_valid.
- done (write): 1 cycle after tx_busy falls following the data byte.
- rx_ready in the same cycle the FSM enters RECV is counted as a response byte.
- Reset mid-transaction: abort immediately. A partial byte sequence may remain on the link; the board-side interface resynchronises on its next header byte.

## Configuration
- CMD_TIMEOUT_EN defined:
  - A counter runs in RECV and clears on entry and on every rx_ready.
  - When it reaches TIMEOUT_CYCLES-1, the read aborts: done pulses, timeout_err is set, rsp_last is not asserted.
  - timeout_err holds until the next request is accepted.
- CMD_TIMEOUT_EN undefined:
  - No counter; timeout_err is tied to 0.
  - RECV waits indefinitely; reset is the only exit.

## Test plan
- Write addr 0 data 0x5A: tx bytes 0xC0 then 0x5A, non-adjacent tx_start pulses, done, no rsp_valid.
- Read addr 4, rdlen 1: tx byte 0x84; inject rx 0x33; rsp_valid with 0x33, rsp_last=1, done the next cycle.
- Read addr 3, rdlen 4: tx 0x83; inject 0x81, 0x22, 0x80, 0x7F; four rsp_valid pulses, rsp_last only on 0x7F; rdlen 0 yields exactly one byte.
- With CMD_TIMEOUT_EN and TIMEOUT_CYCLES=64: read addr 2, no rx; done after 64 cycles in RECV, timeout_err=1; the next accepted request clears it.
- Three rx_ready pulses in IDLE: rx_stray_cnt=3, no rsp_valid; 300 pulses saturate the count at 255.
- Assert reset during RECV of a 4-byte read after 2 bytes: all outputs return to reset values; the next read completes normally.
